// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// Optional overflow trap is enabled by defining MC_CTRL_TRAP_EN.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF     = 5'd0,
    S_ID     = 5'd1,
    S_MEM_EX = 5'd2,
    S_MEM_RD = 5'd3,
    S_LW_WB  = 5'd4,
    S_MEM_WR = 5'd5,
    S_R_EXE  = 5'd6,
    S_R_WB   = 5'd7,
    S_BR_EXE = 5'd8,
    S_J      = 5'd9,
    S_JR     = 5'd10,
    S_JAL    = 5'd11,
    S_I_EXE  = 5'd12,
    S_I_WB   = 5'd13,
    S_LUI_WB = 5'd14,
    S_EXC    = 5'd15
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_OVF  = 2'b01,
    EXC_BUS  = 2'b10,
    EXC_ILL  = 2'b11
  } cause_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  typedef struct packed {
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       IorD;
    logic       CPU_MIO;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       Branch;
    logic       exc;
    logic [1:0] exc_cause;
  } ctrl_t;

  // States that wait on MIO_ready and run the bus-timeout counter.
  function automatic logic is_mio_wait(state_t s);
    return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/MIO bundle.
// master = controller side, slave = datapath/bus side.
interface mc_ctrl_if #(
  parameter int ALU_OP_W = 4
);
  logic [31:0]         Inst_in;
  logic                zero;
  logic                overflow;
  logic                MIO_ready;
  logic                MemRead;
  logic                MemWrite;
  logic                IRWrite;
  logic                IorD;
  logic                CPU_MIO;
  logic                RegWrite;
  logic [1:0]          RegDst;
  logic [1:0]          MemtoReg;
  logic [1:0]          ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [1:0]          PCSource;
  logic                PCWrite;
  logic                PCWriteCond;
  logic                Branch;
  logic [ALU_OP_W-1:0] ALU_operation;
  logic                exc;
  logic [1:0]          exc_cause;
  logic [4:0]          state_out;

  modport master (
    input  Inst_in, zero, overflow, MIO_ready,
    output MemRead, MemWrite, IRWrite, IorD,
    output CPU_MIO, RegWrite, RegDst, MemtoReg,
    output ALUSrcA, ALUSrcB, PCSource, PCWrite,
    output PCWriteCond, Branch, ALU_operation,
    output exc, exc_cause, state_out
  );

  modport slave (
    output Inst_in, zero, overflow, MIO_ready,
    input  MemRead, MemWrite, IRWrite, IorD,
    input  CPU_MIO, RegWrite, RegDst, MemtoReg,
    input  ALUSrcA, ALUSrcB, PCSource, PCWrite,
    input  PCWriteCond, Branch, ALU_operation,
    input  exc, exc_cause, state_out
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Opcode/funct decode: state after ID, ALU op and illegal flag.
// Pure combinational; the caller registers the results.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4
) (
  input  logic [5:0]          opcode_i,
  input  logic [5:0]          funct_i,
  output state_t              nxt_o,
  output logic [ALU_OP_W-1:0] alu_o,
  output logic                shift_o,
  output logic                ovf_chk_o,
  output logic                illegal_o
);

  function automatic logic [ALU_OP_W-1:0] op(input logic [3:0] c);
    return ALU_OP_W'(c);
  endfunction

  // Map the instruction to its execute state and ALU function.
  always_comb begin
    nxt_o     = S_EXC;
    alu_o     = op(ALU_ADD);
    shift_o   = 1'b0;
    ovf_chk_o = 1'b0;
    illegal_o = 1'b1;
    unique case (opcode_i)
      OP_RTYPE: begin
        nxt_o     = S_R_EXE;
        illegal_o = 1'b0;
        unique case (funct_i)
          F_ADD: begin
            alu_o     = op(ALU_ADD);
            ovf_chk_o = 1'b1;
          end
          F_SUB: begin
            alu_o     = op(ALU_SUB);
            ovf_chk_o = 1'b1;
          end
          F_AND:  alu_o = op(ALU_AND);
          F_OR:   alu_o = op(ALU_OR);
          F_XOR:  alu_o = op(ALU_XOR);
          F_NOR:  alu_o = op(ALU_NOR);
          F_SLT:  alu_o = op(ALU_SLT);
          F_SLTU: alu_o = op(ALU_SLTU);
          F_SLL: begin
            alu_o   = op(ALU_SLL);
            shift_o = 1'b1;
          end
          F_SRL: begin
            alu_o   = op(ALU_SRL);
            shift_o = 1'b1;
          end
          F_SRA: begin
            alu_o   = op(ALU_SRA);
            shift_o = 1'b1;
          end
          F_JR: nxt_o = S_JR;
          default: begin
            nxt_o     = S_EXC;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        nxt_o     = S_I_EXE;
        alu_o     = op(ALU_ADD);
        ovf_chk_o = 1'b1;
        illegal_o = 1'b0;
      end
      OP_SLTI: begin
        nxt_o     = S_I_EXE;
        alu_o     = op(ALU_SLT);
        illegal_o = 1'b0;
      end
      OP_SLTIU: begin
        nxt_o     = S_I_EXE;
        alu_o     = op(ALU_SLTU);
        illegal_o = 1'b0;
      end
      OP_ANDI: begin
        nxt_o     = S_I_EXE;
        alu_o     = op(ALU_AND);
        illegal_o = 1'b0;
      end
      OP_ORI: begin
        nxt_o     = S_I_EXE;
        alu_o     = op(ALU_OR);
        illegal_o = 1'b0;
      end
      OP_XORI: begin
        nxt_o     = S_I_EXE;
        alu_o     = op(ALU_XOR);
        illegal_o = 1'b0;
      end
      OP_LW, OP_SW: begin
        nxt_o     = S_MEM_EX;
        illegal_o = 1'b0;
      end
      OP_LUI: begin
        nxt_o     = S_LUI_WB;
        illegal_o = 1'b0;
      end
      OP_BEQ, OP_BNE: begin
        nxt_o     = S_BR_EXE;
        alu_o     = op(ALU_SUB);
        illegal_o = 1'b0;
      end
      OP_J: begin
        nxt_o     = S_J;
        illegal_o = 1'b0;
      end
      OP_JAL: begin
        nxt_o     = S_JAL;
        illegal_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with registered control word.
// Define MC_CTRL_TRAP_EN to trap on signed overflow.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int MIO_TIMEOUT = 255
) (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);

  localparam int CW = $clog2(MIO_TIMEOUT + 1);

  state_t              state_q;
  state_t              state_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  cause_t              cause_d;
  ctrl_t               ctrl_q;
  ctrl_t               ctrl_d;
  logic [ALU_OP_W-1:0] alu_q;
  logic [ALU_OP_W-1:0] alu_d;

  state_t              dec_nxt;
  logic [ALU_OP_W-1:0] dec_alu;
  logic                dec_shift;
  logic                dec_ovf;
  logic                dec_ill;

  logic [5:0] opcode;
  logic       trap;
  logic       tmo;
  logic       fetch_ok;

  assign opcode = bus.Inst_in[31:26];

  mc_ctrl_decode #(
    .ALU_OP_W (ALU_OP_W)
  ) u_dec (
    .opcode_i  (opcode),
    .funct_i   (bus.Inst_in[5:0]),
    .nxt_o     (dec_nxt),
    .alu_o     (dec_alu),
    .shift_o   (dec_shift),
    .ovf_chk_o (dec_ovf),
    .illegal_o (dec_ill)
  );

`ifdef MC_CTRL_TRAP_EN
  assign trap = bus.overflow & dec_ovf;
  wire unused_ok = &{1'b0, bus.zero,
                     bus.Inst_in[25:6]};
`else
  assign trap = 1'b0;
  wire unused_ok = &{1'b0, bus.zero,
                     bus.overflow, dec_ovf,
                     bus.Inst_in[25:6]};
`endif

  // Count reaches MIO_TIMEOUT on this not-ready cycle.
  assign tmo = (cnt_q == CW'(MIO_TIMEOUT - 1));

  // Control word to load on entry to state s.
  function automatic ctrl_t ctrl_word(
    input state_t s,
    input logic   shift,
    input logic   beq,
    input cause_t c
  );
    ctrl_t w;
    w = '0;
    unique case (s)
      S_IF: begin
        w.MemRead = 1'b1;
        w.IRWrite = 1'b1;
        w.CPU_MIO = 1'b1;
        w.ALUSrcB = 2'b01;
        w.PCWrite = 1'b1;
      end
      S_ID: w.ALUSrcB = 2'b11;
      S_MEM_EX: begin
        w.ALUSrcA = 2'b01;
        w.ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        w.IorD    = 1'b1;
        w.CPU_MIO = 1'b1;
        w.MemRead = 1'b1;
        w.ALUSrcA = 2'b01;
        w.ALUSrcB = 2'b10;
      end
      S_MEM_WR: begin
        w.IorD     = 1'b1;
        w.CPU_MIO  = 1'b1;
        w.MemWrite = 1'b1;
        w.ALUSrcA  = 2'b01;
        w.ALUSrcB  = 2'b10;
      end
      S_LW_WB: begin
        w.RegWrite = 1'b1;
        w.MemtoReg = 2'b01;
      end
      S_R_EXE:
        w.ALUSrcA = shift ? 2'b10 : 2'b01;
      S_R_WB: begin
        w.RegWrite = 1'b1;
        w.RegDst   = 2'b01;
      end
      S_BR_EXE: begin
        w.ALUSrcA     = 2'b01;
        w.PCWriteCond = 1'b1;
        w.PCSource    = 2'b01;
        w.Branch      = beq;
      end
      S_J: begin
        w.PCSource = 2'b10;
        w.PCWrite  = 1'b1;
      end
      S_JR: begin
        w.ALUSrcA = 2'b01;
        w.PCWrite = 1'b1;
      end
      S_JAL: begin
        w.RegWrite = 1'b1;
        w.RegDst   = 2'b10;
        w.MemtoReg = 2'b11;
        w.PCSource = 2'b10;
        w.PCWrite  = 1'b1;
      end
      S_I_EXE: begin
        w.ALUSrcA = 2'b01;
        w.ALUSrcB = 2'b10;
      end
      S_I_WB: w.RegWrite = 1'b1;
      S_LUI_WB: begin
        w.RegWrite = 1'b1;
        w.MemtoReg = 2'b10;
      end
      S_EXC: begin
        w.PCSource  = 2'b11;
        w.PCWrite   = 1'b1;
        w.exc       = 1'b1;
        w.exc_cause = c;
      end
      default: ;
    endcase
    return w;
  endfunction

  // Next state, wait counter and exception cause.
  always_comb begin
    state_d = S_IF;
    cnt_d   = '0;
    cause_d = EXC_NONE;
    unique case (state_q)
      S_IF, S_MEM_RD, S_MEM_WR: begin
        if (bus.MIO_ready) begin
          unique case (state_q)
            S_IF:     state_d = S_ID;
            S_MEM_RD: state_d = S_LW_WB;
            default:  state_d = S_IF;
          endcase
        end else if (tmo) begin
          state_d = S_EXC;
          cause_d = EXC_BUS;
        end else begin
          state_d = state_q;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_ID: begin
        state_d = dec_nxt;
        if (dec_ill) cause_d = EXC_ILL;
      end
      S_MEM_EX:
        state_d = (opcode == OP_SW) ? S_MEM_WR
                                    : S_MEM_RD;
      S_R_EXE, S_I_EXE: begin
        if (trap) begin
          state_d = S_EXC;
          cause_d = EXC_OVF;
        end else begin
          state_d = (state_q == S_R_EXE) ? S_R_WB
                                         : S_I_WB;
        end
      end
      default: state_d = S_IF;
    endcase
  end

  // ALU function and control word for the state being entered.
  always_comb begin
    unique case (state_d)
      S_R_EXE, S_I_EXE: alu_d = dec_alu;
      S_BR_EXE:         alu_d = ALU_OP_W'(ALU_SUB);
      default:          alu_d = ALU_OP_W'(ALU_ADD);
    endcase
    ctrl_d = ctrl_word(state_d, dec_shift,
                       opcode == OP_BEQ, cause_d);
  end

  // State, wait counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      alu_q   <= ALU_OP_W'(ALU_ADD);
      ctrl_q  <= ctrl_word(S_IF, 1'b0, 1'b0,
                           EXC_NONE);
    end else begin
      state_q <= state_d;
      cnt_q   <= is_mio_wait(state_d) ? cnt_d : '0;
      alu_q   <= alu_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Fetch must not advance PC or load IR until the bus delivers.
  assign fetch_ok = (state_q != S_IF) || bus.MIO_ready;

  assign bus.MemRead       = ctrl_q.MemRead;
  assign bus.MemWrite      = ctrl_q.MemWrite;
  assign bus.IRWrite       = ctrl_q.IRWrite & fetch_ok;
  assign bus.IorD          = ctrl_q.IorD;
  assign bus.CPU_MIO       = ctrl_q.CPU_MIO;
  assign bus.RegWrite      = ctrl_q.RegWrite;
  assign bus.RegDst        = ctrl_q.RegDst;
  assign bus.MemtoReg      = ctrl_q.MemtoReg;
  assign bus.ALUSrcA       = ctrl_q.ALUSrcA;
  assign bus.ALUSrcB       = ctrl_q.ALUSrcB;
  assign bus.PCSource      = ctrl_q.PCSource;
  assign bus.PCWrite       = ctrl_q.PCWrite & fetch_ok;
  assign bus.PCWriteCond   = ctrl_q.PCWriteCond;
  assign bus.Branch        = ctrl_q.Branch;
  assign bus.ALU_operation = alu_q;
  assign bus.exc           = ctrl_q.exc;
  assign bus.exc_cause     = ctrl_q.exc_cause;
  assign bus.state_out     = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl with MIO_TIMEOUT=4.
// Expectations follow MC_CTRL_TRAP_EN when it is defined.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_if #(.ALU_OP_W(4)) bus ();

  mc_ctrl #(
    .ALU_OP_W    (4),
    .MIO_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [31:0] I_ADD = 32'h00221820;
  localparam logic [31:0] I_LW  = 32'h8C220004;
  localparam logic [31:0] I_SW  = 32'hAC220004;
  localparam logic [31:0] I_BNE = 32'h14220003;
  localparam logic [31:0] I_BEQ = 32'h10220003;
  localparam logic [31:0] I_ILL = 32'hFC000000;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_MEX = 2;
  localparam int ST_MRD = 3;
  localparam int ST_MWR = 5;
  localparam int ST_REX = 6;
  localparam int ST_RWB = 7;
  localparam int ST_BR  = 8;
  localparam int ST_EXC = 15;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.Inst_in   = I_ADD;
    bus.zero      = 1'b0;
    bus.overflow  = 1'b0;
    bus.MIO_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", 32'(bus.state_out), ST_IF);
    chk("rst_alu", 32'(bus.ALU_operation), 2);
    chk("rst_branch", 32'(bus.Branch), 0);
    chk("rst_exc", 32'(bus.exc), 0);
    chk("rst_cause", 32'(bus.exc_cause), 0);
    chk("rst_memrd", 32'(bus.MemRead), 1);
    chk("rst_irwr", 32'(bus.IRWrite), 1);
    chk("rst_srcb", 32'(bus.ALUSrcB), 1);
    chk("rst_pcwr", 32'(bus.PCWrite), 1);
    chk("rst_regwr", 32'(bus.RegWrite), 0);
    reset = 1'b0;

    // ADD, zero wait states
    @(negedge clk);
    chk("add_id", 32'(bus.state_out), ST_ID);
    chk("add_id_srcb", 32'(bus.ALUSrcB), 3);
    chk("add_id_rw", 32'(bus.RegWrite), 0);
    @(negedge clk);
    chk("add_ex", 32'(bus.state_out), ST_REX);
    chk("add_ex_alu", 32'(bus.ALU_operation), 2);
    chk("add_ex_srca", 32'(bus.ALUSrcA), 1);
    chk("add_ex_rw", 32'(bus.RegWrite), 0);
    @(negedge clk);
    chk("add_wb", 32'(bus.state_out), ST_RWB);
    chk("add_wb_rw", 32'(bus.RegWrite), 1);
    chk("add_wb_dst", 32'(bus.RegDst), 1);
    @(negedge clk);
    chk("add_if", 32'(bus.state_out), ST_IF);
    chk("add_if_rw", 32'(bus.RegWrite), 0);

    // Fetch stalled for three cycles
    bus.MIO_ready = 1'b0;
    bus.Inst_in   = I_LW;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ifw_pcwr", 32'(bus.PCWrite), 0);
      chk("ifw_irwr", 32'(bus.IRWrite), 0);
      chk("ifw_state", 32'(bus.state_out), ST_IF);
      @(negedge clk);
    end
    bus.MIO_ready = 1'b1;
    #1;
    chk("ifw_pcwr_rdy", 32'(bus.PCWrite), 1);
    @(negedge clk);
    chk("ifw_id", 32'(bus.state_out), ST_ID);

    // LW whose read never completes
    @(negedge clk);
    chk("lw_mex", 32'(bus.state_out), ST_MEX);
    bus.MIO_ready = 1'b0;
    @(negedge clk);
    chk("lw_mrd_rd", 32'(bus.MemRead), 1);
    chk("lw_mrd_iord", 32'(bus.IorD), 1);
    chk("lw_mrd_mio", 32'(bus.CPU_MIO), 1);
    for (int i = 0; i < 4; i++) begin
      chk("lw_mrd", 32'(bus.state_out), ST_MRD);
      @(negedge clk);
    end
    chk("tmo_state", 32'(bus.state_out), ST_EXC);
    chk("tmo_exc", 32'(bus.exc), 1);
    chk("tmo_cause", 32'(bus.exc_cause), 2);
    chk("tmo_pcsrc", 32'(bus.PCSource), 3);
    chk("tmo_pcwr", 32'(bus.PCWrite), 1);
    bus.MIO_ready = 1'b1;
    bus.Inst_in   = I_ADD;
    @(negedge clk);
    chk("tmo_if", 32'(bus.state_out), ST_IF);
    chk("tmo_exc_clr", 32'(bus.exc), 0);
    chk("tmo_cause_clr", 32'(bus.exc_cause), 0);

    // ADD with signed overflow
    @(negedge clk);
    @(negedge clk);
    chk("ovf_ex", 32'(bus.state_out), ST_REX);
    bus.overflow = 1'b1;
    @(negedge clk);
`ifdef MC_CTRL_TRAP_EN
    chk("ovf_state", 32'(bus.state_out), ST_EXC);
    chk("ovf_cause", 32'(bus.exc_cause), 1);
    chk("ovf_exc", 32'(bus.exc), 1);
    chk("ovf_rw", 32'(bus.RegWrite), 0);
`else
    chk("ovf_state", 32'(bus.state_out), ST_RWB);
    chk("ovf_rw", 32'(bus.RegWrite), 1);
    chk("ovf_exc", 32'(bus.exc), 0);
`endif
    bus.overflow = 1'b0;
    @(negedge clk);
    chk("ovf_if", 32'(bus.state_out), ST_IF);
    chk("ovf_if_rw", 32'(bus.RegWrite), 0);

    // BNE then BEQ
    bus.Inst_in = I_BNE;
    @(negedge clk);
    @(negedge clk);
    chk("bne_state", 32'(bus.state_out), ST_BR);
    chk("bne_branch", 32'(bus.Branch), 0);
    chk("bne_pwc", 32'(bus.PCWriteCond), 1);
    chk("bne_pcsrc", 32'(bus.PCSource), 1);
    chk("bne_alu", 32'(bus.ALU_operation), 6);
    bus.Inst_in = I_BEQ;
    @(negedge clk);
    chk("bne_if", 32'(bus.state_out), ST_IF);
    @(negedge clk);
    @(negedge clk);
    chk("beq_state", 32'(bus.state_out), ST_BR);
    chk("beq_branch", 32'(bus.Branch), 1);

    // Illegal opcode
    bus.Inst_in = I_ILL;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("ill_state", 32'(bus.state_out), ST_EXC);
    chk("ill_exc", 32'(bus.exc), 1);
    chk("ill_cause", 32'(bus.exc_cause), 3);
    @(negedge clk);
    chk("ill_if", 32'(bus.state_out), ST_IF);
    chk("ill_exc_clr", 32'(bus.exc), 0);

    // SW aborted by reset while in MEM_WR
    bus.Inst_in = I_SW;
    @(negedge clk);
    @(negedge clk);
    chk("sw_mex", 32'(bus.state_out), ST_MEX);
    @(negedge clk);
    chk("sw_mwr", 32'(bus.state_out), ST_MWR);
    chk("sw_memwr", 32'(bus.MemWrite), 1);
    bus.MIO_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("swr_state", 32'(bus.state_out), ST_IF);
    chk("swr_memwr", 32'(bus.MemWrite), 0);
    chk("swr_memrd", 32'(bus.MemRead), 1);
    chk("swr_iord", 32'(bus.IorD), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("swr_pcwr", 32'(bus.PCWrite), 0);
    chk("swr_rw", 32'(bus.RegWrite), 0);
    @(negedge clk);
    chk("swr_hold", 32'(bus.state_out), ST_IF);
    chk("swr_hold_mw", 32'(bus.MemWrite), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
